// File: rtl/serial_in_parallel_out_sipo_16_bit_pkg.sv
// Shared constants and word type for the SIPO deserialiser and its downstream consumers.
package serial_in_parallel_out_sipo_16_bit_pkg;

    localparam int unsigned SIPO_DATA_WIDTH = 16;

    typedef logic [SIPO_DATA_WIDTH-1:0] sipo_word_t;

endpackage

// File: rtl/serial_in_parallel_out_sipo_16_bit.sv
// Serial-in, parallel-out shift register: one bit captured per rising edge, whole
// register exposed as a word straight from the flops.
module serial_in_parallel_out_sipo_16_bit
    import serial_in_parallel_out_sipo_16_bit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SIPO_DATA_WIDTH,
    parameter bit          SHIFT_LEFT = 1'b1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Serial_Data_In,
    output logic [DATA_WIDTH-1:0] SIPO_Shift_Register
);

    logic [DATA_WIDTH-1:0] shift_q;

    // Direction is fixed at elaboration; only one branch produces flops.
    generate
        if (SHIFT_LEFT) begin : g_shift_left
            always_ff @(posedge Clk_In or negedge Reset_In) begin
                if (!Reset_In) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= {shift_q[DATA_WIDTH-2:0], Serial_Data_In};
                end
            end
        end else begin : g_shift_right
            always_ff @(posedge Clk_In or negedge Reset_In) begin
                if (!Reset_In) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= {Serial_Data_In, shift_q[DATA_WIDTH-1:1]};
                end
            end
        end
    endgenerate

    assign SIPO_Shift_Register = shift_q;

endmodule

// File: tb/tb_serial_in_parallel_out_sipo_16_bit.sv
// Bench for the SIPO: both shift directions driven by the same stream, checked
// every cycle against a bit-history model plus hand-computed word values.
module tb_serial_in_parallel_out_sipo_16_bit;
    import serial_in_parallel_out_sipo_16_bit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       din;
    sipo_word_t dout_left;
    sipo_word_t dout_right;

    int n_checks = 0;
    int n_pass   = 0;

    // Bits sampled since the last reset, newest at index 0.
    logic hist[$];

    serial_in_parallel_out_sipo_16_bit #(
        .DATA_WIDTH (16),
        .SHIFT_LEFT (1'b1)
    ) u_dut_left (
        .Clk_In              (clk),
        .Reset_In            (rst_n),
        .Serial_Data_In      (din),
        .SIPO_Shift_Register (dout_left)
    );

    serial_in_parallel_out_sipo_16_bit #(
        .DATA_WIDTH (16),
        .SHIFT_LEFT (1'b0)
    ) u_dut_right (
        .Clk_In              (clk),
        .Reset_In            (rst_n),
        .Serial_Data_In      (din),
        .SIPO_Shift_Register (dout_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_front(din);
            if (hist.size() > 16) void'(hist.pop_back());
        end
    end

    // Word implied by history: bit sampled i edges ago sits i places from the entry end.
    function automatic sipo_word_t model_word(bit left);
        sipo_word_t w = '0;
        for (int i = 0; i < 16 && i < hist.size(); i++) begin
            if (left) w[i] = hist[i];
            else      w[15-i] = hist[i];
        end
        return w;
    endfunction

    task automatic check(string name, sipo_word_t act, sipo_word_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model_left", dout_left, model_word(1'b1));
        check("model_right", dout_right, model_word(1'b0));
    end

    task automatic step(logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the immediate clear, releases away from an edge.
    task automatic pulse_reset(string name);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_left"}, dout_left, 16'h0000);
        check({name, "_right"}, dout_right, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        sipo_word_t w;
        logic [15:0] pat;
        rst_n = 1'b0;
        din   = 1'b0;

        // Held in reset while the serial input toggles.
        for (int i = 0; i < 6; i++) begin
            step(logic'(i % 2 == 0));
            check("hold_reset", dout_left, 16'h0000);
        end
        #1 rst_n = 1'b1;
        step(1'b1);
        step(1'b1);
        pulse_reset("async_clear");

        // Single one walks from the entry end to the far end.
        step(1'b1);
        check("one_edge1_left", dout_left, 16'h0001);
        check("one_edge1_right", dout_right, 16'h8000);
        for (int i = 0; i < 15; i++) step(1'b0);
        check("one_edge16_left", dout_left, 16'h8000);
        check("one_edge16_right", dout_right, 16'h0001);
        step(1'b0);
        check("one_discard_left", dout_left, 16'h0000);

        // Ramp of ones, then a zero on the 17th edge.
        pulse_reset("ramp_reset");
        for (int k = 1; k <= 16; k++) begin
            step(1'b1);
            check("ramp_left", dout_left, 16'((32'd1 << k) - 32'd1));
        end
        step(1'b0);
        check("ramp_edge17_left", dout_left, 16'hFFFE);
        check("ramp_edge17_right", dout_right, 16'h7FFF);

        // Alternating pattern MSB first, then random bits in arrival order.
        pulse_reset("alt_reset");
        for (int i = 0; i < 16; i++) step(logic'(i % 2 == 0));
        check("alt_left", dout_left, 16'hAAAA);
        check("alt_right", dout_right, 16'h5555);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            logic b;
            b = logic'($urandom_range(1, 0));
            w = {w[14:0], b};
            step(b);
        end
        check("random_word_left", dout_left, w);

        // Reset mid-word, then a known word MSB first.
        for (int i = 0; i < 7; i++) step(logic'($urandom_range(1, 0)));
        pulse_reset("midword_reset");
        pat = 16'h1234;
        for (int i = 15; i >= 0; i--) step(pat[i]);
        check("word_1234_left", dout_left, 16'h1234);
        check("word_1234_right", dout_right, 16'h2C48);

        // Long random stream with occasional resets, checked by the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(39, 0) == 0) pulse_reset("random_reset");
            else step(logic'($urandom_range(1, 0)));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
